// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin shared-bus arbiter with data/control mux and hold-timeout watchdog
module bus_rr_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int CTRL_WIDTH = 8,
  parameter int NUM_REQ = 8,
  parameter int MAX_HOLD = 256
) (
  input  logic                           clk,
  input  logic                           rst_L,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   bus_in,
  input  logic [NUM_REQ*CTRL_WIDTH-1:0]  ctrl_in,
  output logic [NUM_REQ-1:0]             ack,
  output logic [BUS_WIDTH-1:0]           bus_out,
  output logic [CTRL_WIDTH-1:0]          ctrl_out,
  output logic [2:0]                     grant_id,
  output logic                           bus_busy,
  output logic                           timeout_err
);
  localparam int HW = $clog2(MAX_HOLD + 2);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_nx;
  logic [2:0] rr_ptr, win;
  logic [HW-1:0] hold_cnt;
  logic [NUM_REQ-1:0] lockout, elig, gmask;
  logic tmo;
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state <= IDLE;
      rr_ptr <= 3'd7;
      grant_id <= '0;
      hold_cnt <= '0;
      lockout <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      timeout_err <= tmo;
      lockout <= (lockout & req) | (tmo ? gmask : '0);
      hold_cnt <= state != GRANT ? '0 : hold_cnt == HW'(MAX_HOLD) ? hold_cnt : hold_cnt + 1'b1;
      if (state == IDLE && |elig) begin
        grant_id <= win;
        rr_ptr <= win;
      end
    end
  end
  always_comb begin
    elig = req & ~lockout;
    win = '0;
    for (int k = NUM_REQ; k > 0; k--)
      win = elig[rr_ptr + 3'(k)] ? rr_ptr + 3'(k) : win;
    gmask = NUM_REQ'(1) << grant_id;
    tmo = state == GRANT && req[grant_id] && MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD - 1);
    state_nx = state == IDLE ? (|elig ? GRANT : IDLE) :
               state == GRANT ? (!req[grant_id] || tmo ? RELEASE : GRANT) : IDLE;
  end
  always_comb begin
    bus_busy = state == GRANT;
    ack = bus_busy ? gmask : '0;
    bus_out = bus_busy ? bus_in[grant_id*BUS_WIDTH +: BUS_WIDTH] : '0;
    ctrl_out = bus_busy ? ctrl_in[grant_id*CTRL_WIDTH +: CTRL_WIDTH] : '0;
  end
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb_bus_rr_arbiter: directed self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;
  logic clk = 1'b0;
  logic rst_L;
  logic [7:0] req_a, req_b;
  logic [255:0] bus_in;
  logic [63:0] ctrl_in;
  logic [7:0] ack, ack4;
  logic [31:0] bus_out, bus_out4;
  logic [7:0] ctrl_out, ctrl_out4;
  logic [2:0] grant_id, grant_id4;
  logic bus_busy, bus_busy4, timeout_err, timeout_err4;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  bus_rr_arbiter dut (
    .clk(clk), .rst_L(rst_L), .req(req_a), .bus_in(bus_in), .ctrl_in(ctrl_in),
    .ack(ack), .bus_out(bus_out), .ctrl_out(ctrl_out), .grant_id(grant_id),
    .bus_busy(bus_busy), .timeout_err(timeout_err)
  );
  bus_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst_L(rst_L), .req(req_b), .bus_in(bus_in), .ctrl_in(ctrl_in),
    .ack(ack4), .bus_out(bus_out4), .ctrl_out(ctrl_out4), .grant_id(grant_id4),
    .bus_busy(bus_busy4), .timeout_err(timeout_err4)
  );
  always @(negedge clk) begin
    n_cmp++;
    if (!$onehot0(ack) || (|ack) !== bus_busy) begin
      n_bad++;
      $display("FAIL inv_ack: ack %h busy %b, required one-hot-or-zero matching busy", ack, bus_busy);
    end
    n_cmp++;
    if (!$onehot0(ack4) || (|ack4) !== bus_busy4) begin
      n_bad++;
      $display("FAIL inv_ack4: ack %h busy %b, required one-hot-or-zero matching busy", ack4, bus_busy4);
    end
  end
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst_L = 1'b0;
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 8; i++) begin
      bus_in[i*32 +: 32] = 32'hB000_0000 + 32'(i) * 32'h111;
      ctrl_in[i*8 +: 8] = 8'hC0 + 8'(i);
    end
    step();
    n_cmp++; if (ack !== 8'h00 || bus_busy !== 1'b0) begin n_bad++; $display("FAIL rst_ack: got %h/%b want 00/0", ack, bus_busy); end
    n_cmp++; if (grant_id !== 3'd0 || timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_gid: got %0d/%b want 0/0", grant_id, timeout_err); end
    n_cmp++; if (bus_out !== 32'h0 || ctrl_out !== 8'h0) begin n_bad++; $display("FAIL rst_bus: got %h/%h want 0/0", bus_out, ctrl_out); end
    n_cmp++; if (ack4 !== 8'h00 || timeout_err4 !== 1'b0) begin n_bad++; $display("FAIL rst_ack4: got %h/%b want 00/0", ack4, timeout_err4); end
    rst_L = 1'b1;
    step();
    n_cmp++; if (ack !== 8'h00 || bus_out !== 32'h0) begin n_bad++; $display("FAIL idle_noreq: got %h/%h want 00/0", ack, bus_out); end
  endtask
  task automatic test_single();
    req_a = 8'h80;
    step();
    n_cmp++; if (ack !== 8'h80 || grant_id !== 3'd7) begin n_bad++; $display("FAIL single_ack: got %h/%0d want 80/7", ack, grant_id); end
    n_cmp++; if (bus_out !== 32'hB000_0777 || ctrl_out !== 8'hC7) begin n_bad++; $display("FAIL single_bus: got %h/%h want b0000777/c7", bus_out, ctrl_out); end
    for (int c = 0; c < 8; c++) step();
    bus_in[7*32 +: 32] = 32'h1234_5678;
    #1;
    n_cmp++; if (bus_out !== 32'h1234_5678 || ack !== 8'h80) begin n_bad++; $display("FAIL single_track: got %h/%h want 12345678/80", bus_out, ack); end
    bus_in[7*32 +: 32] = 32'hB000_0777;
    step();
    req_a = 8'h00;
    step();
    n_cmp++; if (ack !== 8'h00 || bus_busy !== 1'b0) begin n_bad++; $display("FAIL single_rel_ack: got %h/%b want 00/0", ack, bus_busy); end
    n_cmp++; if (bus_out !== 32'h0 || ctrl_out !== 8'h0) begin n_bad++; $display("FAIL single_rel_bus: got %h/%h want 0/0", bus_out, ctrl_out); end
    step();
    n_cmp++; if (ack !== 8'h00 || bus_out !== 32'h0) begin n_bad++; $display("FAIL single_idle: got %h/%h want 00/0", ack, bus_out); end
  endtask
  task automatic test_alternate();
    logic [2:0] e;
    req_a = 8'h81;
    step();
    for (int g = 0; g < 4; g++) begin
      e = (g % 2) ? 3'd7 : 3'd0;
      for (int c = 0; c < 3; c++) begin
        n_cmp++; if (ack !== (8'(1) << e) || grant_id !== e) begin n_bad++; $display("FAIL alt_grant%0d: got %h/%0d want %h/%0d", g, ack, grant_id, 8'(1) << e, e); end
        if (c < 2) step();
      end
      req_a[e] = 1'b0;
      step();
      n_cmp++; if (ack !== 8'h00 || bus_out !== 32'h0) begin n_bad++; $display("FAIL alt_rel%0d: got %h/%h want 00/0", g, ack, bus_out); end
      req_a[e] = 1'b1;
      step();
      n_cmp++; if (ack !== 8'h00) begin n_bad++; $display("FAIL alt_gap%0d: got %h want 00", g, ack); end
      step();
    end
    n_cmp++; if (ack !== 8'h01) begin n_bad++; $display("FAIL alt_wrap: got %h want 01", ack); end
    req_a = 8'h00;
    step();
    step();
  endtask
  task automatic test_back_to_back();
    logic [2:0] e;
    rst_L = 1'b0;
    step();
    rst_L = 1'b1;
    req_a = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      e = 3'(g);
      step();
      n_cmp++; if (ack !== (8'(1) << e) || grant_id !== e) begin n_bad++; $display("FAIL b2b_grant%0d: got %h/%0d want %h/%0d", g, ack, grant_id, 8'(1) << e, e); end
      n_cmp++; if (bus_out !== 32'hB000_0000 + 32'(e) * 32'h111) begin n_bad++; $display("FAIL b2b_bus%0d: got %h want %h", g, bus_out, 32'hB000_0000 + 32'(e) * 32'h111); end
      req_a[e] = 1'b0;
      step();
      n_cmp++; if (ack !== 8'h00) begin n_bad++; $display("FAIL b2b_rel%0d: got %h want 00", g, ack); end
      req_a[e] = 1'b1;
      step();
    end
    req_a = 8'h00;
    step();
    n_cmp++; if (ack !== 8'h00) begin n_bad++; $display("FAIL b2b_end: got %h want 00", ack); end
  endtask
  task automatic test_timeout();
    req_b = 8'h01;
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (ack4 !== 8'h01 || timeout_err4 !== 1'b0) begin n_bad++; $display("FAIL to_hold%0d: got %h/%b want 01/0", c, ack4, timeout_err4); end
    end
    step();
    n_cmp++; if (ack4 !== 8'h00 || timeout_err4 !== 1'b1) begin n_bad++; $display("FAIL to_fire: got %h/%b want 00/1", ack4, timeout_err4); end
    n_cmp++; if (bus_out4 !== 32'h0) begin n_bad++; $display("FAIL to_bus: got %h want 0", bus_out4); end
    for (int c = 0; c < 4; c++) begin
      step();
      n_cmp++; if (ack4 !== 8'h00 || timeout_err4 !== 1'b0) begin n_bad++; $display("FAIL to_lock%0d: got %h/%b want 00/0", c, ack4, timeout_err4); end
    end
    req_b = 8'h00;
    step();
    req_b = 8'h01;
    step();
    n_cmp++; if (ack4 !== 8'h01 || grant_id4 !== 3'd0) begin n_bad++; $display("FAIL to_regrant: got %h/%0d want 01/0", ack4, grant_id4); end
    req_b = 8'h00;
    step();
    step();
  endtask
  task automatic test_drop_at_timeout();
    req_b = 8'h01;
    for (int c = 0; c < 4; c++) step();
    n_cmp++; if (ack4 !== 8'h01) begin n_bad++; $display("FAIL drop_hold: got %h want 01", ack4); end
    req_b = 8'h00;
    step();
    n_cmp++; if (ack4 !== 8'h00 || timeout_err4 !== 1'b0) begin n_bad++; $display("FAIL drop_noerr: got %h/%b want 00/0", ack4, timeout_err4); end
    req_b = 8'h01;
    step();
    n_cmp++; if (ack4 !== 8'h00 || timeout_err4 !== 1'b0) begin n_bad++; $display("FAIL drop_idle: got %h/%b want 00/0", ack4, timeout_err4); end
    step();
    n_cmp++; if (ack4 !== 8'h01) begin n_bad++; $display("FAIL drop_regrant: got %h want 01", ack4); end
    req_b = 8'h00;
    step();
    step();
  endtask
  task automatic test_async_reset();
    req_a = 8'h01;
    step();
    n_cmp++; if (ack !== 8'h01 || bus_out !== 32'hB000_0000) begin n_bad++; $display("FAIL ar_grant: got %h/%h want 01/b0000000", ack, bus_out); end
    #2 rst_L = 1'b0;
    #1;
    n_cmp++; if (ack !== 8'h00 || bus_busy !== 1'b0) begin n_bad++; $display("FAIL ar_ack: got %h/%b want 00/0", ack, bus_busy); end
    n_cmp++; if (bus_out !== 32'h0 || ctrl_out !== 8'h0) begin n_bad++; $display("FAIL ar_bus: got %h/%h want 0/0", bus_out, ctrl_out); end
    step();
    rst_L = 1'b1;
    req_a = 8'h03;
    step();
    n_cmp++; if (ack !== 8'h01 || grant_id !== 3'd0) begin n_bad++; $display("FAIL ar_prio: got %h/%0d want 01/0", ack, grant_id); end
    req_a = 8'h00;
    step();
    step();
  endtask
  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_timeout();
    test_drop_at_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Shared-bus arbiter and data/control multiplexer for the system bus connecting the test master, the micron_controller SRAM slave and future requesters.
- Accepts up to 8 req lines and grants exactly one requester at a time, using round-robin priority.
- Routes the granted requester's bus/ctrl outputs onto the shared bus.
- Enforces a hold-timeout watchdog so a stuck master cannot starve the SRAM path.

Parameters:
- BUS_WIDTH, 32, width of the shared data bus.
- CTRL_WIDTH, 8, width of the shared control bus.
- NUM_REQ, 8, number of requesters. Fixed at 8 in this revision; ports are sized from it.
- MAX_HOLD, 256, maximum grant length in cycles before forced release. 0 disables the timeout.

Ports:
- clk  input  1  system clock (50 MHz); all state updates on its rising edge.
- rst_L  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request lines; bit i belongs to requester i.
- bus_in  input  NUM_REQ*BUS_WIDTH  packed requester data; slice i = bits [i*BUS_WIDTH +: BUS_WIDTH].
- ctrl_in  input  NUM_REQ*CTRL_WIDTH  packed requester control; slice i likewise.
- ack  output  NUM_REQ  one-hot grant (or all zero), registered.
- bus_out  output  BUS_WIDTH  shared data bus.
- ctrl_out  output  CTRL_WIDTH  shared control bus.
- grant_id  output  3  index of the current grantee; valid while bus_busy=1.
- bus_busy  output  1  high while in GRANT state.
- timeout_err  output  1  one-cycle pulse on forced release.

Behaviour:
Reset (rst_L=0, async):
- ack=0, grant_id=0, bus_busy=0, timeout_err=0.
- state=IDLE, rr_ptr=7 (so requester 0 has highest priority first), hold_cnt=0, lockout=0.
- Reset asserted mid-grant drops ack immediately; no RELEASE cycle follows.

States: IDLE, GRANT, RELEASE.

IDLE:
- Eligible requesters are req & ~lockout.
- If any are eligible, pick the first set bit scanning from rr_ptr+1 upward, wrapping from 7 to 0.
- At the next edge: ack[winner]=1, grant_id=winner, rr_ptr=winner, hold_cnt=0, state=GRANT.
- Latency is 1 cycle from req sampled high to ack high.

GRANT:
- Each cycle: hold_cnt increments, saturating at MAX_HOLD.
- If req[grant_id]=0 at an edge: ack=0, state=RELEASE.
- Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: ack=0, timeout_err=1 for one cycle, lockout[grant_id]=1, state=RELEASE. The requester therefore holds for exactly MAX_HOLD cycles.
- Other requesters' req changes are ignored; no preemption.

RELEASE:
- Exactly one dead cycle with bus_out=0 and ctrl_out=0 (bus turnaround).
- Then state=IDLE.
- Back-to-back grants are therefore ack-low for 2 cycles minimum: the RELEASE cycle plus the IDLE decision cycle.

lockout[i]:
- Cleared at any edge where req[i]=0.
- A timed-out master must drop req for at least 1 cycle before it can be granted again.
- Lockout does not block other requesters.

Mux (combinational from registered state):
- In GRANT: bus_out = bus_in slice grant_id, ctrl_out = ctrl_in slice grant_id.
- Otherwise both are 0.

Simultaneous events:
- req drop and timeout on the same edge: treated as a normal release; no timeout_err, no lockout.
- All req low in IDLE: stay in IDLE with outputs 0.
- rr_ptr updates only on grant, never on release or timeout.

Invariants (bench checks these as assertions):
- ack is one-hot or zero at all times.
- ack != 0 if and only if bus_busy=1.

Test Plan:
- Reset then req=8'h80 held 10 cycles → ack=8'h80 one cycle after req; bus_out tracks bus_in slice 7; drop req → ack=0 next edge, bus_out=0 for RELEASE, IDLE after.
- req=8'h81 constant, each master drops req after 3 grant cycles and re-raises → grants alternate 0,7,0,7 with a 2-cycle gap between acks; first grant to 0.
- req=8'hFF all held with single-cycle drops on release → grant order 0,1,2,...,7,0; no requester granted twice before every other pending requester has been granted once.
- MAX_HOLD=4, req=8'h01 held high → ack high exactly 4 cycles, timeout_err pulses once, no regrant while req stays high; req low 1 cycle then high → regranted.
- MAX_HOLD=4, req[0] drops on the same edge the timeout would fire → no timeout_err, lockout[0]=0.
- rst_L pulsed low during GRANT → ack, bus_busy, bus_out go to 0 asynchronously; after release, requester 0 has priority again.
